// File: rtl/lsb_mem_responder.sv
// lsb_mem_responder: serialises LSB load/store requests onto a byte-wide RAM/IO bus.
// Ports: clk, rst (sync, active-high), rdy (global enable), and the request side:
//   lsb_flag, lsb_is_write, lsb_addr, lsb_wdata, lsb_op in; lsb_rdata, mem_ok out.
//   RAM side: mem_din in; mem_dout, mem_a, mem_wr out.
//   io_buffer_full in: present only when MEMCTRL_IO_STALL_EN is defined.
// Opcodes: LB=11 LH=12 LW=13 LBU=14 LHU=15 SB=16 SH=17 SW=18; any other value moves 4 bytes.
// Loads return raw bytes (upper bytes zero); sign extension is left to the LSB.
module lsb_mem_responder #(
  parameter int          ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              lsb_flag,
  input  logic              lsb_is_write,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic [5:0]        lsb_op,
  output logic [31:0]       lsb_rdata,
  output logic              mem_ok,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
`ifdef MEMCTRL_IO_STALL_EN
  ,
  input  logic              io_buffer_full
`endif
);

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        size;
  } req_t;

  logic [1:0] state;
  logic [2:0] idx;
  logic [2:0] size_dec;
  logic       op_b;
  logic       op_h;
  req_t       req;

  assign op_b = (lsb_op == OP_LB) || (lsb_op == OP_LBU) ||
                (lsb_op == OP_SB);
  assign op_h = (lsb_op == OP_LH) || (lsb_op == OP_LHU) ||
                (lsb_op == OP_SH);

  always_comb begin
    size_dec = 3'd4;
    unique case (1'b1)
      op_b:    size_dec = 3'd1;
      op_h:    size_dec = 3'd2;
      default: size_dec = 3'd4;
    endcase
  end

  logic unused_ops;
  assign unused_ops = (lsb_op == OP_LW) | (lsb_op == OP_SW);

`ifdef MEMCTRL_IO_STALL_EN
  // io_gap inserts one bus-idle cycle after each byte sent to the IO region.
  logic io_gap;
  logic io_region;
  assign io_region = (req.addr[17:16] == IO_SEL);
`endif

  // READ uses idx as a step counter: steps 0..N-1 issue addresses,
  // steps 2..N+1 capture the byte requested two steps earlier,
  // since the RAM answers one cycle after it samples mem_a.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 3'd0;
      req       <= '0;
      mem_ok    <= 1'b0;
      lsb_rdata <= 32'd0;
      mem_wr    <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= 8'd0;
`ifdef MEMCTRL_IO_STALL_EN
      io_gap    <= 1'b0;
`endif
    end else if (!rdy) begin
      mem_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_ok <= 1'b0;
          mem_wr <= 1'b0;
          if (lsb_flag) begin
            req.addr  <= lsb_addr;
            req.wdata <= lsb_wdata;
            req.size  <= size_dec;
            idx       <= 3'd0;
`ifdef MEMCTRL_IO_STALL_EN
            io_gap    <= 1'b0;
`endif
            if (lsb_is_write) begin
              state <= S_WRITE;
            end else begin
              state     <= S_READ;
              lsb_rdata <= 32'd0;
            end
          end
        end
        S_READ: begin
          mem_wr <= 1'b0;
          if (idx < req.size)
            mem_a <= req.addr + ADDR_W'(idx);
          if (idx >= 3'd2)
            lsb_rdata[{idx[1:0] - 2'd2, 3'b000} +: 8] <= mem_din;
          if (idx == req.size + 3'd1) begin
            state  <= S_DONE;
            mem_ok <= 1'b1;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        S_WRITE: begin
          if (idx == req.size) begin
            mem_wr <= 1'b0;
            state  <= S_DONE;
            mem_ok <= 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
          end else if (io_region && (io_gap || io_buffer_full)) begin
            mem_wr <= 1'b0;
            io_gap <= 1'b0;
`endif
          end else begin
            mem_a    <= req.addr + ADDR_W'(idx);
            mem_dout <= req.wdata[{idx[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            idx      <= idx + 3'd1;
`ifdef MEMCTRL_IO_STALL_EN
            io_gap   <= io_region;
`endif
          end
        end
        S_DONE: begin
          // The LSB still holds lsb_flag here; it is deliberately ignored.
          mem_ok <= 1'b0;
          mem_wr <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          mem_ok <= 1'b0;
          mem_wr <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_mem_responder.sv
// tb_lsb_mem_responder: randomized self-checking bench for lsb_mem_responder.
// Byte RAM model on the bus side; expected values come from a size/byte-order model.
module tb_lsb_mem_responder;

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;
  localparam logic [5:0] OP_BAD = 6'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        lsb_flag;
  logic        lsb_is_write;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_rdata;
  logic        mem_ok;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEMCTRL_IO_STALL_EN
  logic        io_buffer_full;
`endif

  logic [7:0]  ram [0:65535];
  logic [7:0]  model [logic [15:0]];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  logic        pl_en;
  logic [15:0] pl_a;
  logic [7:0]  pl_d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsb_mem_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsb_flag(lsb_flag), .lsb_is_write(lsb_is_write),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_op(lsb_op),
    .lsb_rdata(lsb_rdata), .mem_ok(mem_ok),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MEMCTRL_IO_STALL_EN
    , .io_buffer_full(io_buffer_full)
`endif
  );

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_a] <= pl_d;
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
    mem_din <= ram[mem_a[15:0]];
  end

  function automatic int size_of(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a,
                                           input int n);
    logic [31:0] v = 32'd0;
    logic [31:0] p;
    for (int k = 0; k < n; k++) begin
      p = a + k;
      v = v | ({24'd0, model[p[15:0]]} << (8 * k));
    end
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    model[a[15:0]] = d;
    pl_en = 1'b1;
    pl_a = a[15:0];
    pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and follow the handshake the way the LSB does.
  // lat = edges from accept to first mem_ok, okw = mem_ok high cycles,
  // nrd = distinct addresses seen on mem_a while the request ran.
  task automatic run_req(input logic w, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int okw, output int nrd);
    logic [31:0] seen [$];
    bit found;
    lsb_flag = 1'b1;
    lsb_is_write = w;
    lsb_op = op;
    lsb_addr = a;
    lsb_wdata = wd;
    lat = -1;
    okw = 0;
    for (int e = 0; e <= 60 && lat < 0; e++) begin
      @(negedge clk);
      if (e >= 1) begin
        found = 0;
        foreach (seen[i]) if (seen[i] == mem_a) found = 1;
        if (!found) seen.push_back(mem_a);
      end
      if (mem_ok === 1'b1) lat = e;
    end
    if (lat >= 0) begin
      @(negedge clk);
      okw = (mem_ok === 1'b1) ? 2 : 1;
    end
    lsb_flag = 1'b0;
    nrd = seen.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    lsb_flag = 1'b0;
    lsb_is_write = 1'b0;
    lsb_addr = 32'd0;
    lsb_wdata = 32'd0;
    lsb_op = OP_LW;
    pl_en = 1'b0;
    pl_a = 16'd0;
    pl_d = 8'd0;
`ifdef MEMCTRL_IO_STALL_EN
    io_buffer_full = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_ok, mem_wr, lsb_rdata, mem_a, mem_dout} !== 74'd0) begin
      miscompares++;
      $display("FAIL reset: ok=%b wr=%b rdata=%h a=%h dout=%h want all 0",
               mem_ok, mem_wr, lsb_rdata, mem_a, mem_dout);
    end
  endtask

  task automatic test_lw_example();
    int lat, okw, nrd;
    preload(32'h100, 8'h11);
    preload(32'h101, 8'h22);
    preload(32'h102, 8'h33);
    preload(32'h103, 8'h44);
    run_req(1'b0, OP_LW, 32'h100, 32'd0, lat, okw, nrd);
    vectors++;
    if (lsb_rdata !== 32'h44332211 || lat != 6 || okw != 1) begin
      miscompares++;
      $display("FAIL lw_example: rdata=%h lat=%0d okw=%0d want 44332211/6/1",
               lsb_rdata, lat, okw);
    end
  endtask

  task automatic test_lb_example();
    int lat, okw, nrd;
    preload(32'h203, 8'h80);
    run_req(1'b0, OP_LB, 32'h203, 32'd0, lat, okw, nrd);
    vectors++;
    if (lsb_rdata !== 32'h80 || lat != 3 || okw != 1 || nrd != 1) begin
      miscompares++;
      $display("FAIL lb_example: rdata=%h lat=%0d okw=%0d nrd=%0d want 80/3/1/1",
               lsb_rdata, lat, okw, nrd);
    end
  endtask

  task automatic test_sh_example();
    int lat, okw, nrd, b;
    logic [31:0] keep;
    keep = lsb_rdata;
    b = wlog_a.size();
    run_req(1'b1, OP_SH, 32'h10, 32'hDEADBEEF, lat, okw, nrd);
    vectors++;
    if (wlog_a.size() - b != 2 || wlog_a[b] !== 32'h10 ||
        wlog_d[b] !== 8'hEF || wlog_a[b+1] !== 32'h11 ||
        wlog_d[b+1] !== 8'hBE || lat != 3 || okw != 1 ||
        lsb_rdata !== keep) begin
      miscompares++;
      $display("FAIL sh_example: nwr=%0d lat=%0d okw=%0d rdata=%h want 2/3/1/%h",
               wlog_a.size() - b, lat, okw, lsb_rdata, keep);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, okw, nrd, b;
    b = wlog_a.size();
    run_req(1'b1, OP_SB, 32'h40, 32'h000000A5, lat1, okw, nrd);
    run_req(1'b1, OP_SB, 32'h50, 32'h0000005A, lat2, okw, nrd);
    vectors++;
    if (wlog_a.size() - b != 2 || wlog_a[b] !== 32'h40 ||
        wlog_d[b] !== 8'hA5 || wlog_a[b+1] !== 32'h50 ||
        wlog_d[b+1] !== 8'h5A || lat1 != 2 || lat2 != 2) begin
      miscompares++;
      $display("FAIL back_to_back: nwr=%0d lat1=%0d lat2=%0d want 2/2/2",
               wlog_a.size() - b, lat1, lat2);
    end
  endtask

  task automatic test_wrap();
    int lat, okw, nrd;
    logic [31:0] exp;
    preload(32'hFFFFFFFE, 8'hA1);
    preload(32'hFFFFFFFF, 8'hB2);
    preload(32'h00000000, 8'hC3);
    preload(32'h00000001, 8'hD4);
    exp = 32'hD4C3B2A1;
    run_req(1'b0, OP_LW, 32'hFFFFFFFE, 32'd0, lat, okw, nrd);
    vectors++;
    if (lsb_rdata !== exp || lat != 6 || nrd != 4) begin
      miscompares++;
      $display("FAIL wrap: rdata=%h lat=%0d nrd=%0d want %h/6/4",
               lsb_rdata, lat, nrd, exp);
    end
  endtask

  task automatic test_rst_mid();
    int lat, okw, nrd, bad;
    lsb_flag = 1'b1;
    lsb_is_write = 1'b0;
    lsb_op = OP_LW;
    lsb_addr = 32'h100;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    lsb_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (lsb_rdata !== 32'd0 || mem_a !== 32'd0 || mem_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_regs: rdata=%h a=%h wr=%b want 0/0/0",
               lsb_rdata, mem_a, mem_wr);
    end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_ok !== 1'b0 || mem_wr !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: bad cycles=%0d want 0", bad);
    end
    run_req(1'b0, OP_LB, 32'h203, 32'd0, lat, okw, nrd);
    vectors++;
    if (lsb_rdata !== 32'h80 || lat != 3) begin
      miscompares++;
      $display("FAIL rst_mid_recover: rdata=%h lat=%0d want 80/3",
               lsb_rdata, lat);
    end
  endtask

  task automatic test_rdy_stall();
    int b, lat, bad;
    logic [31:0] wd;
    wd = $urandom;
    b = wlog_a.size();
    lsb_flag = 1'b1;
    lsb_is_write = 1'b1;
    lsb_op = OP_SW;
    lsb_addr = 32'h30;
    lsb_wdata = wd;
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr !== 1'b0 || mem_ok !== 1'b0) bad++;
    end
    rdy = 1'b1;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rdy_stall_wr: active cycles=%0d want 0", bad);
    end
    lat = -1;
    for (int e = 6; e <= 40 && lat < 0; e++) begin
      @(negedge clk);
      if (mem_ok === 1'b1) lat = e;
    end
    @(negedge clk);
    lsb_flag = 1'b0;
    vectors++;
    if (lat != 8 || wlog_a.size() - b != 4) begin
      miscompares++;
      $display("FAIL rdy_stall_timing: lat=%0d nwr=%0d want 8/4",
               lat, wlog_a.size() - b);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wlog_a[b+k] !== 32'h30 + k || wlog_d[b+k] !== wd[8*k +: 8]) begin
        miscompares++;
        $display("FAIL rdy_stall_byte%0d: got (%h,%h) want (%h,%h)", k,
                 wlog_a[b+k], wlog_d[b+k], 32'h30 + k, wd[8*k +: 8]);
      end
    end
  endtask

  task automatic test_io_region();
    int lat, okw, nrd, b, want;
    b = wlog_a.size();
    run_req(1'b1, OP_SH, 32'h00030000, 32'h00001234, lat, okw, nrd);
`ifdef MEMCTRL_IO_STALL_EN
    want = 4;
`else
    want = 3;
`endif
    vectors++;
    if (lat != want || wlog_a.size() - b != 2 ||
        wlog_d[b] !== 8'h34 || wlog_d[b+1] !== 8'h12) begin
      miscompares++;
      $display("FAIL io_region: lat=%0d nwr=%0d want %0d/2", lat,
               wlog_a.size() - b, want);
    end
`ifdef MEMCTRL_IO_STALL_EN
    b = wlog_a.size();
    io_buffer_full = 1'b1;
    lsb_flag = 1'b1;
    lsb_is_write = 1'b1;
    lsb_op = OP_SB;
    lsb_addr = 32'h00030000;
    lsb_wdata = 32'h0000007E;
    nrd = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_wr !== 1'b0) nrd++;
    end
    io_buffer_full = 1'b0;
    lat = -1;
    for (int e = 5; e <= 40 && lat < 0; e++) begin
      @(negedge clk);
      if (mem_ok === 1'b1) lat = e;
    end
    @(negedge clk);
    lsb_flag = 1'b0;
    vectors++;
    if (nrd != 0 || lat != 6 || wlog_a.size() - b != 1 ||
        wlog_d[b] !== 8'h7E) begin
      miscompares++;
      $display("FAIL io_stall: early_wr=%0d lat=%0d nwr=%0d want 0/6/1",
               nrd, lat, wlog_a.size() - b);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] lops [6] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_BAD};
    logic [5:0] sops [4] = '{OP_SB, OP_SH, OP_SW, OP_BAD};
    for (int it = 0; it < 40; it++) begin
      logic w;
      logic [5:0] op;
      logic [31:0] a, wd, keep, exp;
      int n, lat, okw, nrd, b;
      w = 1'($urandom_range(0, 1));
      op = w ? sops[$urandom_range(0, 3)] : lops[$urandom_range(0, 5)];
      n = size_of(op);
      a = $urandom & 32'hFFFD_FFFF;
      wd = $urandom;
      if (!w)
        for (int k = 0; k < n; k++) preload(a + k, 8'($urandom));
      keep = lsb_rdata;
      exp = w ? keep : load_val(a, n);
      b = wlog_a.size();
      run_req(w, op, a, wd, lat, okw, nrd);
      vectors++;
      if (lsb_rdata !== exp || lat != n + (w ? 1 : 2) || okw != 1) begin
        miscompares++;
        $display("FAIL rand%0d op=%0d w=%b: rdata=%h lat=%0d okw=%0d want %h/%0d/1",
                 it, op, w, lsb_rdata, lat, okw, exp, n + (w ? 1 : 2));
      end
      if (w) begin
        vectors++;
        if (wlog_a.size() - b != n) begin
          miscompares++;
          $display("FAIL rand%0d nwr: got %0d want %0d", it,
                   wlog_a.size() - b, n);
        end
        for (int k = 0; k < n; k++) begin
          model[16'(a + k)] = wd[8*k +: 8];
          vectors++;
          if (wlog_a[b+k] !== a + k || wlog_d[b+k] !== wd[8*k +: 8]) begin
            miscompares++;
            $display("FAIL rand%0d byte%0d: got (%h,%h) want (%h,%h)", it, k,
                     wlog_a[b+k], wlog_d[b+k], a + k, wd[8*k +: 8]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_example();
    test_lb_example();
    test_sh_example();
    test_back_to_back();
    test_wrap();
    test_rst_mid();
    test_rdy_stall();
    test_io_region();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
